// File: rtl/weighted_round_robin_pkg.sv
// Shared defaults and index helpers for the weighted round-robin arbiter.
package weighted_round_robin_pkg;

    localparam int DEF_QUEUE_QUANTITY = 4;
    localparam int DEF_SEL_BITS       = 2;
    localparam int DEF_WEIGHT_BITS    = 3;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_next_eligible.sv
// Combinational circular priority finder: first eligible index at or after start.
module rr_next_eligible
    import weighted_round_robin_pkg::*;
#(
    parameter int QUEUE_QUANTITY = DEF_QUEUE_QUANTITY,
    parameter int SEL_BITS       = DEF_SEL_BITS
) (
    input  logic [QUEUE_QUANTITY-1:0] eligible_i,
    input  logic [SEL_BITS-1:0]       start_i,
    output logic                      found_o,
    output logic [SEL_BITS-1:0]       index_o
);

    always_comb begin
        int   cand;
        logic hit;
        hit     = 1'b0;
        index_o = '0;
        cand    = 0;
        for (int k = 0; k < QUEUE_QUANTITY; k++) begin
            cand = (int'(start_i) + k) % QUEUE_QUANTITY;
            if (!hit && eligible_i[cand[SEL_BITS-1:0]]) begin
                hit     = 1'b1;
                index_o = cand[SEL_BITS-1:0];
            end
        end
        found_o = hit;
    end

endmodule

// File: rtl/weighted_round_robin.sv
// Weighted round-robin arbiter: per-queue burst quanta, empty/disabled skipping,
// downstream backpressure, registered selector/out_enb/one-hot grant.
module weighted_round_robin
    import weighted_round_robin_pkg::*;
#(
    parameter int QUEUE_QUANTITY = DEF_QUEUE_QUANTITY,
    parameter int SEL_BITS       = DEF_SEL_BITS,
    parameter int WEIGHT_BITS    = DEF_WEIGHT_BITS
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enb,
    input  logic [QUEUE_QUANTITY-1:0]           buf_empty,
    input  logic                                dest_full,
    input  logic [QUEUE_QUANTITY*WEIGHT_BITS-1:0] weights,
    output logic [SEL_BITS-1:0]                 selector,
    output logic                                out_enb,
    output logic [QUEUE_QUANTITY-1:0]           grant
);

    logic [SEL_BITS-1:0]       ptr_q, ptr_d, sel_q, sel_d;
    logic [SEL_BITS-1:0]       start, found_idx, target;
    logic [WEIGHT_BITS-1:0]    cnt_q, cnt_d, base;
    logic [WEIGHT_BITS:0]      next_cnt;
    logic [WEIGHT_BITS-1:0]    weight_arr [QUEUE_QUANTITY];
    logic [QUEUE_QUANTITY-1:0] eligible, grant_q, grant_d;
    logic                      out_enb_q, out_enb_d;
    logic                      found, ptr_elig, any_elig, burst_end;

    always_comb begin
        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            weight_arr[i] = weights[i*WEIGHT_BITS +: WEIGHT_BITS];
            eligible[i]   = !buf_empty[i] && (weight_arr[i] != '0);
        end
    end

    // The current holder is checked directly; the finder only covers the other queues
    // (its circular search ends back at ptr, which is harmless).
    assign start = SEL_BITS'(wrap_inc(32'(ptr_q), 32'(QUEUE_QUANTITY)));

    rr_next_eligible #(
        .QUEUE_QUANTITY (QUEUE_QUANTITY),
        .SEL_BITS       (SEL_BITS)
    ) u_next (
        .eligible_i (eligible),
        .start_i    (start),
        .found_o    (found),
        .index_o    (found_idx)
    );

    assign ptr_elig  = eligible[ptr_q];
    assign any_elig  = ptr_elig | found;
    assign target    = ptr_elig ? ptr_q : found_idx;
    assign base      = ptr_elig ? cnt_q : '0;
    assign next_cnt  = {1'b0, base} + (WEIGHT_BITS+1)'(1);
    assign burst_end = next_cnt >= {1'b0, weight_arr[target]};

    always_comb begin
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        out_enb_d = 1'b0;
        grant_d   = '0;
        if (enb && !dest_full && any_elig) begin
            out_enb_d = 1'b1;
            sel_d     = target;
            grant_d   = QUEUE_QUANTITY'(1) << target;
            if (burst_end) begin
                ptr_d = SEL_BITS'(wrap_inc(32'(target), 32'(QUEUE_QUANTITY)));
                cnt_d = '0;
            end else begin
                ptr_d = target;
                cnt_d = next_cnt[WEIGHT_BITS-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q     <= '0;
            cnt_q     <= '0;
            sel_q     <= '0;
            out_enb_q <= 1'b0;
            grant_q   <= '0;
        end else begin
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            out_enb_q <= out_enb_d;
            grant_q   <= grant_d;
        end
    end

    assign selector = sel_q;
    assign out_enb  = out_enb_q;
    assign grant    = grant_q;

endmodule

// File: tb/tb_weighted_round_robin.sv
// Directed bench for weighted_round_robin with a per-cycle reference model.
module tb_weighted_round_robin;

    localparam int N = 4;
    localparam int W = 3;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           enb = 1'b0;
    logic [N-1:0]   buf_empty = '1;
    logic           dest_full = 1'b0;
    logic [N*W-1:0] weights = '0;
    logic [S-1:0]   selector;
    logic           out_enb;
    logic [N-1:0]   grant;

    int nvec = 0;
    int nerr = 0;
    bit run  = 1'b0;

    // reference model state
    int         m_ptr = 0;
    int         m_cnt = 0;
    int         m_sel = 0;
    bit         m_oe  = 1'b0;
    logic [N-1:0] m_grant = '0;

    weighted_round_robin #(
        .QUEUE_QUANTITY (N),
        .SEL_BITS       (S),
        .WEIGHT_BITS    (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .buf_empty (buf_empty),
        .dest_full (dest_full),
        .weights   (weights),
        .selector  (selector),
        .out_enb   (out_enb),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    function automatic int wt(input int q);
        logic [W-1:0] f;
        f = weights[q*W +: W];
        return int'(f);
    endfunction

    always @(posedge clk or negedge rst) begin
        int t;
        int base;
        int q;
        if (!rst) begin
            m_ptr = 0; m_cnt = 0; m_sel = 0; m_oe = 1'b0; m_grant = '0;
        end else if (enb && !dest_full) begin
            t = -1;
            for (int k = 0; k < N; k++) begin
                q = (m_ptr + k) % N;
                if (t < 0 && !buf_empty[q] && wt(q) != 0) t = q;
            end
            if (t >= 0) begin
                m_oe    = 1'b1;
                m_sel   = t;
                m_grant = '0;
                m_grant[t] = 1'b1;
                base = (t == m_ptr) ? m_cnt : 0;
                if (base + 1 >= wt(t)) begin
                    m_ptr = (t + 1) % N;
                    m_cnt = 0;
                end else begin
                    m_ptr = t;
                    m_cnt = base + 1;
                end
            end else begin
                m_oe = 1'b0; m_grant = '0;
            end
        end else begin
            m_oe = 1'b0; m_grant = '0;
        end
    end

    always @(negedge clk) begin
        if (run && rst) begin
            nvec++;
            if (int'(selector) !== m_sel || out_enb !== m_oe || grant !== m_grant) begin
                nerr++;
                $display("FAIL model t=%0t got sel=%0d oe=%0b grant=%b expected sel=%0d oe=%0b grant=%b",
                         $time, selector, out_enb, grant, m_sel, m_oe, m_grant);
            end
        end
    end

    task automatic chk(input string name, input int esel, input bit eoe, input logic [N-1:0] eg);
        nvec++;
        if (int'(selector) !== esel || out_enb !== eoe || grant !== eg) begin
            nerr++;
            $display("FAIL %s got sel=%0d oe=%0b grant=%b expected sel=%0d oe=%0b grant=%b",
                     name, selector, out_enb, grant, esel, eoe, eg);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic step_grant(input string name, input int esel);
        logic [N-1:0] g;
        tick();
        g = '0;
        g[esel] = 1'b1;
        chk(name, esel, 1'b1, g);
    endtask

    task automatic step_idle(input string name, input int esel);
        tick();
        chk(name, esel, 1'b0, '0);
    endtask

    task automatic set_w(input int w0, input int w1, input int w2, input int w3);
        weights = {W'(w3), W'(w2), W'(w1), W'(w0)};
    endtask

    // called just after a falling edge; release lands before the next rising edge
    task automatic pulse_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        int s1[5]  = '{0, 1, 2, 3, 0};
        int s2[10] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
        int s3[7]  = '{1, 3, 1, 3, 1, 1, 1};
        int s5[6]  = '{3, 0, 1, 3, 0, 1};

        #1 rst = 1'b0;
        tick();
        tick();
        chk("reset_state", 0, 1'b0, '0);
        run = 1'b1;

        // rotation with unit weights
        set_w(1, 1, 1, 1);
        buf_empty = '0;
        enb = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) step_grant("rotate", s1[i]);

        // weighted bursts
        tick();
        pulse_reset();
        set_w(3, 1, 2, 1);
        for (int i = 0; i < 10; i++) step_grant("burst", s2[i]);

        // empty skipping, then a single eligible queue
        tick();
        pulse_reset();
        set_w(1, 1, 1, 1);
        buf_empty = 4'b0101;
        for (int i = 0; i < 4; i++) step_grant("skip", s3[i]);
        buf_empty = 4'b1101;
        for (int i = 4; i < 7; i++) step_grant("single", s3[i]);

        // backpressure mid-burst
        tick();
        pulse_reset();
        buf_empty = '0;
        set_w(3, 1, 1, 1);
        step_grant("bp_first", 0);
        dest_full = 1'b1;
        step_idle("bp_hold", 0);
        step_idle("bp_hold", 0);
        dest_full = 1'b0;
        step_grant("bp_resume", 0);
        step_grant("bp_resume", 0);
        step_grant("bp_next", 1);

        // nothing eligible, then one queue disabled
        buf_empty = '1;
        step_idle("all_empty", 1);
        step_idle("all_empty", 1);
        buf_empty = '0;
        set_w(0, 0, 0, 0);
        step_idle("all_zero_w", 1);
        set_w(1, 1, 0, 1);
        for (int i = 0; i < 6; i++) step_grant("q2_off", s5[i]);

        // async reset mid-burst
        tick();
        pulse_reset();
        set_w(3, 1, 1, 1);
        step_grant("pre_reset", 0);
        #2 rst = 1'b0;
        #1 chk("async_reset", 0, 1'b0, '0);
        #1 rst = 1'b1;
        step_grant("post_reset", 0);
        step_grant("post_reset", 0);
        step_grant("post_reset", 0);
        step_grant("post_reset", 1);

        // enable freeze and weight lowered mid-burst
        tick();
        pulse_reset();
        set_w(3, 1, 1, 1);
        step_grant("freeze_a", 0);
        enb = 1'b0;
        step_idle("freeze", 0);
        enb = 1'b1;
        set_w(1, 1, 1, 1);
        step_grant("lowered", 0);
        step_grant("lowered_next", 1);

        // wrap from last queue back to 0
        step_grant("wrap", 2);
        step_grant("wrap", 3);
        step_grant("wrap", 0);

        tick();
        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

endmodule
